// File: rtl/memory_responder.sv
// Three-phase memory responder (FETCH -> ACCESS -> STEP) with a program-preload port.
// Optional memory-mapped output port enabled by defining MEMORY_RESPONDER_IO_EN.
module memory_responder #(
  parameter int unsigned           ADDR_BITS = 8,
  parameter logic [ADDR_BITS-1:0]  IO_ADDR   = '1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic [15:0] addr,
  input  logic [15:0] out,
  input  logic        write,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] instruction,
  output logic [15:0] data,
  output logic        step,
  output logic [15:0] io_out,
  output logic        io_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

`ifdef MEMORY_RESPONDER_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    FETCH,
    ACCESS,
    STEP
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            instruction_q, instruction_d;
  logic [15:0]            data_q, data_d;
  logic [15:0]            io_out_q, io_out_d;
  logic                   io_valid_q, io_valid_d;

  logic [15:0]            mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [15:0]            mem_wdata;

  logic [ADDR_BITS-1:0]   pc_idx, addr_idx, load_idx;
  logic                   io_hit;
  logic                   unused_hi;

  assign pc_idx    = pc[ADDR_BITS-1:0];
  assign addr_idx  = addr[ADDR_BITS-1:0];
  assign load_idx  = load_addr[ADDR_BITS-1:0];
  // Upper address bits are deliberately ignored: addresses wrap modulo the depth.
  assign unused_hi = ^{pc, addr, load_addr};
  assign io_hit    = IO_EN && (addr_idx == IO_ADDR);

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    data_d        = data_q;
    io_out_d      = io_out_q;
    io_valid_d    = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = addr_idx;
    mem_wdata     = out;

    if (load_en) begin
      // Preload owns the single write port and freezes the sequencer in FETCH.
      mem_we    = 1'b1;
      mem_waddr = load_idx;
      mem_wdata = load_data;
      state_d   = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          instruction_d = mem[pc_idx];
          state_d       = ACCESS;
        end
        ACCESS: begin
          if (write) begin
            if (io_hit) begin
              io_out_d   = out;
              io_valid_d = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            data_d = io_hit ? io_out_q : mem[addr_idx];
          end
          state_d = STEP;
        end
        STEP:    state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end

    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      instruction_q <= '0;
      data_q        <= '0;
      io_out_q      <= '0;
      io_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      data_q        <= data_d;
      io_out_q      <= io_out_d;
      io_valid_q    <= io_valid_d;
    end
  end

  // Memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instruction = instruction_q;
  assign data        = data_q;
  assign step        = (state_q == STEP) && !load_en && !reset;
  assign io_out      = IO_EN ? io_out_q : '0;
  assign io_valid    = IO_EN ? io_valid_q : 1'b0;

endmodule
